rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Sequences the register file's single write port (we/a3/wd3) among N_REQ writeback requesters, e.g. ALU/CSR result, multi-cycle load unit, debug write.
- Uses round-robin arbitration with a valid/ready handshake and a registered output stage.
- Keeps a 32-entry busy scoreboard of destinations reserved at issue and cleared when their writeback is granted. The hazard logic reads this scoreboard.
- Sits between the execute/memory/debug sources and the register file's write port.

Parameters:
- WIDTH, 32, data width; matches register file width.
- N_REQ, 3, number of writeback requesters (2..8).
- ADDR_W, 5, register address width; 32 registers.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  requester i has a writeback pending.
- req_ready  out  N_REQ  grant to requester i; the transfer occurs when valid&ready.
- req_addr  in  N_REQ*ADDR_W  destination of requester i, packed, slice i at [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*WIDTH  write data of requester i, packed, slice i at [i*WIDTH +: WIDTH].
- hold  in  1  freeze: no grants while high.
- rsv_valid  in  1  reserve destination rsv_addr (issue of a long-latency op).
- rsv_addr  in  ADDR_W  destination to reserve.
- rf_we  out  1  to register file we.
- rf_a3  out  ADDR_W  to register file a3.
- rf_wd3  out  WIDTH  to register file wd3.
- busy_vec  out  32  bit r set = register r has a reserved, not-yet-granted write.

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_a3=0, rf_wd3=0, busy_vec=0.
  - Round-robin pointer=0.
  - req_ready=0 while rst_n=0.
  - Reset mid-operation discards any staged write; it is never presented to the register file.
- Arbitration (combinational within cycle T):
  - If hold=1, req_ready=0.
  - Otherwise, grant exactly one valid requester. Search starts at index ptr, ascending with wrap-around mod N_REQ.
  - req_ready is one-hot or zero and never asserted for an invalid requester.
  - ready depends on valid, so requesters must not make valid depend on ready.
- Pointer update: on a grant to i at edge T, ptr <= (i+1) mod N_REQ. With no grant, ptr is unchanged.
- Output stage, registered, 1-cycle latency:
  - A grant at cycle T gives rf_we=1, rf_a3=addr_i, rf_wd3=data_i during T+1. The register file commits at the end of T+1.
  - Cycles with no grant give rf_we=0. rf_a3 and rf_wd3 hold their previous values.
  - The output stage drains every cycle. Back-to-back grants yield one write per cycle, so throughput is 1 write/cycle.
- x0 handling: a granted request with addr=0 completes its handshake normally, but the output stage loads rf_we=0.
- Scoreboard:
  - rsv_valid with rsv_addr!=0 sets busy[rsv_addr] at the edge.
  - A grant to addr a!=0 clears busy[a] at the same edge.
  - Set and clear of the same address on the same edge: set wins, because it is a newer reservation.
  - rsv_addr=0 is ignored; busy[0] is always 0.
  - A grant to a non-busy address is legal (single-cycle ops are not reserved).
  - busy_vec is a registered output.
- Fairness: with all N_REQ requesters continuously valid and hold=0, each is granted once every N_REQ cycles.
- Starvation-free: a requester that stays valid is granted within N_REQ cycles of hold going low.

Decomposition:
- Shared package rf_pkg:
  - ADDR_W and NUM_REGS=32 constants.
  - typedef reg_addr_t (logic [ADDR_W-1:0]).
  - typedef wb_req_t struct {valid, addr, data}, used by requesters.
- One natural sub-module: rr_arbiter (parameter N; inputs req vector, ptr, enable; outputs one-hot grant and grant index). It is reusable for a later memory-port arbiter.
- The scoreboard and output stage stay inline.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with a staged write to x5 → rf_we=0 immediately (async), busy_vec=0, ptr=0. After release, the first grant goes to req0 when all are valid.
- Round-robin: req0..2 all valid continuously, addrs 1/2/3, data 0xA/0xB/0xC → rf_we=1 every cycle from T+1, rf_a3 sequence 1,2,3,1,2,3…, one ready per cycle.
- Hold: all valid, hold=1 for 4 cycles → req_ready=0 and rf_we=0 throughout. After hold drops, grants resume from the saved ptr.
- x0 write: req1 valid, addr=0, data=0xDEAD → req_ready[1]=1, next cycle rf_we=0, busy_vec unchanged.
- Scoreboard: rsv x7 at T → busy_vec[7]=1 at T+1. Load requester grants addr 7 at T+3 → busy_vec[7]=0 at T+4, with rf_we=1, rf_a3=7 during T+4.
- Simultaneous set/clear: rsv_valid on x9 on the same edge as a grant to x9 → busy_vec[9]=1 afterwards, and the write to x9 still appears on rf_we next cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions: architectural constants and the writeback request payload.
package rf_pkg;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DATA_W   = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic              valid;
        reg_addr_t         addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after i_ptr, wrapping mod N.
module rr_arbiter #(
    parameter int unsigned N = 3,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [N-1:0]     o_grant_c,
    output logic [IDX_W-1:0] o_grant_idx_c
);

    logic w_found;

    always_comb begin
        int unsigned idx;
        o_grant_c     = '0;
        o_grant_idx_c = '0;
        w_found       = 1'b0;
        idx           = 0;
        if (i_en) begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = (32'(i_ptr) + k) % N;
                if (!w_found && i_req[IDX_W'(idx)]) begin
                    o_grant_c[IDX_W'(idx)] = 1'b1;
                    o_grant_idx_c          = IDX_W'(idx);
                    w_found                = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant of the single write port among N_REQ
// requesters, registered write stage, and a busy scoreboard of reserved destinations.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*WIDTH-1:0]  req_data,
    input  logic                    hold,
    input  logic                    rsv_valid,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic                    rf_we,
    output logic [ADDR_W-1:0]       rf_a3,
    output logic [WIDTH-1:0]        rf_wd3,
    output logic [NUM_REGS-1:0]     busy_vec
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0]    r_ptr;
    logic                r_we;
    logic [ADDR_W-1:0]   r_a3;
    logic [WIDTH-1:0]    r_wd3;
    logic [NUM_REGS-1:0] r_busy;

    logic                w_arb_en;
    logic [N_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_any;
    logic [ADDR_W-1:0]   w_addr;
    logic [WIDTH-1:0]    w_data;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // No grants while frozen or held in reset.
    assign w_arb_en = ~hold & rst_n;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .i_req         (req_valid),
        .i_ptr         (r_ptr),
        .i_en          (w_arb_en),
        .o_grant_c     (w_grant),
        .o_grant_idx_c (w_grant_idx)
    );

    assign w_any     = |w_grant;
    assign req_ready = w_grant;

    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (w_any) begin
            w_ptr_nxt = (32'(w_grant_idx) + 1 >= N_REQ) ? '0 : IDX_W'(32'(w_grant_idx) + 1);
        end
    end

    // Clear on grant first so a same-edge reservation (newer) wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_any && (w_addr != '0)) begin
            w_busy_nxt[w_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_we   <= 1'b0;
            r_a3   <= '0;
            r_wd3  <= '0;
            r_busy <= '0;
        end else begin
            r_ptr  <= w_ptr_nxt;
            r_we   <= w_any && (w_addr != '0);
            r_busy <= w_busy_nxt;
            if (w_any) begin
                r_a3  <= w_addr;
                r_wd3 <= w_data;
            end
        end
    end

    assign rf_we    = r_we;
    assign rf_a3    = r_a3;
    assign rf_wd3   = r_wd3;
    assign busy_vec = r_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed, table-driven bench for rf_wb_arbiter plus a hand-written async reset sequence.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        hold;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic [31:0] busy_vec;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter #(
        .WIDTH  (32),
        .N_REQ  (3),
        .ADDR_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .hold      (hold),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd3    (rf_wd3),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic        hold;
        logic        rsv_v;
        logic [4:0]  rsv_a;
        logic [2:0]  exp_ready;
        logic        exp_we;
        logic        chk_out;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd3;
        logic [31:0] exp_busy;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [2:0] valid, input logic [14:0] addr, input logic hld,
                                input logic rv, input logic [4:0] ra, input logic [2:0] er,
                                input logic ew, input logic co, input logic [4:0] ea,
                                input logic [31:0] ed, input logic [31:0] eb);
        vec_t v;
        v.valid = valid; v.addr = addr; v.hold = hld; v.rsv_v = rv; v.rsv_a = ra;
        v.exp_ready = er; v.exp_we = ew; v.chk_out = co; v.exp_a3 = ea;
        v.exp_wd3 = ed; v.exp_busy = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [14:0] A123 = {5'd3, 5'd2, 5'd1};
    localparam logic [14:0] A0X0 = {5'd3, 5'd0, 5'd1};
    localparam logic [14:0] A7   = {5'd3, 5'd2, 5'd7};
    localparam logic [14:0] A9   = {5'd9, 5'd9, 5'd7};

    initial begin
        // valid addr hold rsv_v rsv_a | ready we chk a3 wd3 busy (outputs after the edge)
        vecs[0]  = mk(3'b111, A123, 0, 0, 0,  3'b001, 1, 1, 5'd1, 32'hA, 32'h0);
        vecs[1]  = mk(3'b111, A123, 0, 0, 0,  3'b010, 1, 1, 5'd2, 32'hB, 32'h0);
        vecs[2]  = mk(3'b111, A123, 0, 0, 0,  3'b100, 1, 1, 5'd3, 32'hC, 32'h0);
        vecs[3]  = mk(3'b111, A123, 0, 0, 0,  3'b001, 1, 1, 5'd1, 32'hA, 32'h0);
        vecs[4]  = mk(3'b111, A123, 1, 0, 0,  3'b000, 0, 1, 5'd1, 32'hA, 32'h0);
        vecs[5]  = mk(3'b111, A123, 1, 0, 0,  3'b000, 0, 1, 5'd1, 32'hA, 32'h0);
        vecs[6]  = mk(3'b111, A123, 1, 0, 0,  3'b000, 0, 1, 5'd1, 32'hA, 32'h0);
        vecs[7]  = mk(3'b111, A123, 1, 0, 0,  3'b000, 0, 1, 5'd1, 32'hA, 32'h0);
        vecs[8]  = mk(3'b111, A123, 0, 0, 0,  3'b010, 1, 1, 5'd2, 32'hB, 32'h0);
        vecs[9]  = mk(3'b001, A123, 0, 0, 0,  3'b001, 1, 1, 5'd1, 32'hA, 32'h0);
        vecs[10] = mk(3'b100, A123, 0, 0, 0,  3'b100, 1, 1, 5'd3, 32'hC, 32'h0);
        vecs[11] = mk(3'b000, A123, 0, 0, 0,  3'b000, 0, 1, 5'd3, 32'hC, 32'h0);
        vecs[12] = mk(3'b010, A0X0, 0, 0, 0,  3'b010, 0, 0, 5'd0, 32'h0, 32'h0);
        vecs[13] = mk(3'b000, A7,   0, 1, 7,  3'b000, 0, 0, 5'd0, 32'h0, 32'h80);
        vecs[14] = mk(3'b000, A7,   0, 0, 0,  3'b000, 0, 0, 5'd0, 32'h0, 32'h80);
        vecs[15] = mk(3'b001, A7,   0, 0, 0,  3'b001, 1, 1, 5'd7, 32'hA, 32'h0);
        vecs[16] = mk(3'b000, A9,   0, 1, 9,  3'b000, 0, 1, 5'd7, 32'hA, 32'h200);
        vecs[17] = mk(3'b010, A9,   0, 1, 9,  3'b010, 1, 1, 5'd9, 32'hB, 32'h200);
        vecs[18] = mk(3'b100, A9,   0, 0, 0,  3'b100, 1, 1, 5'd9, 32'hC, 32'h0);
        vecs[19] = mk(3'b000, A9,   0, 1, 0,  3'b000, 0, 1, 5'd9, 32'hC, 32'h0);

        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = A123;
        req_data  = {32'hC, 32'hB, 32'hA};
        hold      = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        #2;
        check("reset we",    32'(rf_we),     32'h0);
        check("reset a3",    32'(rf_a3),     32'h0);
        check("reset wd3",   rf_wd3,         32'h0);
        check("reset busy",  busy_vec,       32'h0);
        req_valid = 3'b111;
        #1;
        check("reset ready", 32'(req_ready), 32'h0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            req_valid = vecs[i].valid;
            req_addr  = vecs[i].addr;
            hold      = vecs[i].hold;
            rsv_valid = vecs[i].rsv_v;
            rsv_addr  = vecs[i].rsv_a;
            #1;
            check($sformatf("v%0d ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d we", i), 32'(rf_we), 32'(vecs[i].exp_we));
            check($sformatf("v%0d busy", i), busy_vec, vecs[i].exp_busy);
            if (vecs[i].chk_out) begin
                check($sformatf("v%0d a3", i), 32'(rf_a3), 32'(vecs[i].exp_a3));
                check($sformatf("v%0d wd3", i), rf_wd3, vecs[i].exp_wd3);
            end
        end

        // Stage a write to x5 (pointer moves to 1), then reset while another grant is in flight.
        req_valid = 3'b001;
        req_addr  = {5'd3, 5'd2, 5'd5};
        hold      = 1'b0;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd12;
        @(posedge clk);
        #1;
        rsv_valid = 1'b0;
        req_valid = 3'b111;
        check("stage we",   32'(rf_we), 32'h1);
        check("stage a3",   32'(rf_a3), 32'h5);
        check("stage busy", busy_vec,   32'h1000);
        #1;
        check("stage ready", 32'(req_ready), 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst we",    32'(rf_we),     32'h0);
        check("async rst a3",    32'(rf_a3),     32'h0);
        check("async rst wd3",   rf_wd3,         32'h0);
        check("async rst busy",  busy_vec,       32'h0);
        check("async rst ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        check("rst discard we", 32'(rf_we), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post rst ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        check("post rst we",  32'(rf_we), 32'h1);
        check("post rst a3",  32'(rf_a3), 32'h5);
        check("post rst wd3", rf_wd3,     32'hA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
